led_blink_bank: RTL and testbench

LED_BLINK_BANK -- requirements
Module: led_blink_bank

---
 rtl/led_blink_bank.sv | 152 +++++++++++++++
 tb/tb_led_blink_bank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_bank.sv
// Bank of NCH independent LED channels (OFF / ON / BLINK / ONESHOT) configured over a valid/ready port.
// Optional per-channel brightness gating is compiled in with LED_PWM_EN.
module led_blink_bank #(
  parameter int          NCH      = 4,
  parameter int          CNT_W    = 28,
  parameter int unsigned HALF_RST = 50000000,
  localparam int         CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_half,
`ifdef LED_PWM_EN
  input  logic [7:0]       cfg_duty,
`endif
  output logic [NCH-1:0]   led,
  output logic [NCH-1:0]   tick
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_INIT = (HALF_RST == 0) ? ONE : CNT_W'(HALF_RST);

  mode_e            mode_q [NCH];
  mode_e            mode_d [NCH];
  logic [CNT_W-1:0] half_q [NCH];
  logic [CNT_W-1:0] half_d [NCH];
  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [CNT_W-1:0] cnt_d  [NCH];
  logic [NCH-1:0]   state_q, state_d;
  logic [NCH-1:0]   tick_d, led_d;
  logic             ready_q, ready_d;
  logic             accept;

`ifdef LED_PWM_EN
  logic [7:0] pwm_q, pwm_d;
  logic [7:0] duty_q [NCH];
  logic [7:0] duty_d [NCH];
`endif

  assign cfg_ready = ready_q;

  always_comb begin
    accept  = ready_q && cfg_valid;
    ready_d = !accept;
    state_d = state_q;
    tick_d  = '0;
    led_d   = '0;
`ifdef LED_PWM_EN
    pwm_d = pwm_q + 8'd1;
`endif
    for (int i = 0; i < NCH; i++) begin
      mode_d[i] = mode_q[i];
      half_d[i] = half_q[i];
      cnt_d[i]  = cnt_q[i];
`ifdef LED_PWM_EN
      duty_d[i] = duty_q[i];
`endif
      // A config landing on the terminal cycle takes priority over the toggle.
      if (accept && (int'(cfg_ch) == i)) begin
        mode_d[i]  = mode_e'(cfg_mode);
        half_d[i]  = (cfg_half == '0) ? ONE : cfg_half;
        cnt_d[i]   = '0;
        state_d[i] = cfg_mode[0];
`ifdef LED_PWM_EN
        duty_d[i]  = cfg_duty;
`endif
      end else begin
        case (mode_q[i])
          MODE_OFF: begin
            cnt_d[i]   = '0;
            state_d[i] = 1'b0;
          end
          MODE_ON: begin
            cnt_d[i]   = '0;
            state_d[i] = 1'b1;
          end
          MODE_BLINK: begin
            if (cnt_q[i] == half_q[i] - ONE) begin
              cnt_d[i]   = '0;
              state_d[i] = !state_q[i];
              tick_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + ONE;
            end
          end
          default: begin
            if (cnt_q[i] == half_q[i] - ONE) begin
              cnt_d[i]   = '0;
              state_d[i] = 1'b0;
              mode_d[i]  = MODE_OFF;
              tick_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + ONE;
            end
          end
        endcase
      end
`ifdef LED_PWM_EN
      led_d[i] = state_d[i] && (pwm_q < duty_d[i]);
`else
      led_d[i] = state_d[i];
`endif
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ready_q <= 1'b0;
      state_q <= '0;
      led     <= '0;
      tick    <= '0;
      for (int i = 0; i < NCH; i++) begin
        mode_q[i] <= MODE_BLINK;
        half_q[i] <= HALF_INIT;
        cnt_q[i]  <= '0;
`ifdef LED_PWM_EN
        duty_q[i] <= 8'hFF;
`endif
      end
`ifdef LED_PWM_EN
      pwm_q <= 8'd0;
`endif
    end else begin
      ready_q <= ready_d;
      state_q <= state_d;
      led     <= led_d;
      tick    <= tick_d;
      for (int i = 0; i < NCH; i++) begin
        mode_q[i] <= mode_d[i];
        half_q[i] <= half_d[i];
        cnt_q[i]  <= cnt_d[i];
`ifdef LED_PWM_EN
        duty_q[i] <= duty_d[i];
`endif
      end
`ifdef LED_PWM_EN
      pwm_q <= pwm_d;
`endif
    end
  end

endmodule

// File: tb/tb_led_blink_bank.sv
// Directed bench for led_blink_bank: expected tick events are queued per channel by the stimulus
// and consumed by an independent monitor whenever the DUT pulses tick.
module tb_led_blink_bank;
  localparam int NCH      = 3;
  localparam int CNT_W    = 8;
  localparam int HALF_RST = 5;
  localparam int CH_W     = 2;

  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_ON    = 2'b01;
  localparam logic [1:0] M_BLINK = 2'b10;
  localparam logic [1:0] M_ONE   = 2'b11;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_half;
  logic [NCH-1:0]   led;
  logic [NCH-1:0]   tick;
`ifdef LED_PWM_EN
  logic [7:0]       cfg_duty = 8'hFF;
`endif

  led_blink_bank #(.NCH(NCH), .CNT_W(CNT_W), .HALF_RST(HALF_RST)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_half (cfg_half),
`ifdef LED_PWM_EN
    .cfg_duty (cfg_duty),
`endif
    .led      (led),
    .tick     (tick)
  );

  always #5 sys_clk = ~sys_clk;

  // Edges since reset release; edge n is labelled cycle n.
  int cyc;
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  typedef struct {
    int   cyc;
    logic lv;
  } ev_t;

  ev_t expq [NCH][$];
  ev_t mon_e;
  int  n_chk  = 0;
  int  n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int ch, input int c, input logic lv);
    ev_t e;
    e.cyc = c;
    e.lv  = lv;
    expq[ch].push_back(e);
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      for (int i = 0; i < NCH; i++) begin
        if (tick[i]) begin
          if (expq[i].size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_tick ch%0d: got tick at cycle %0d, expected none", i, cyc);
          end else begin
            mon_e = expq[i].pop_front();
            chk($sformatf("tick_cycle_ch%0d", i), cyc, mon_e.cyc);
            chk($sformatf("tick_led_ch%0d", i), int'(led[i]), int'(mon_e.lv));
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Issue one config; checks the handshake and the led vector right after acceptance.
  task automatic cfg(input int ch, input logic [1:0] mode, input int half, input int exp_led);
    chk("ready_before_cfg", int'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_mode  = mode;
    cfg_half  = CNT_W'(half);
    @(posedge sys_clk);
    #1;
    cfg_valid = 1'b0;
    chk("ready_low_after_accept", int'(cfg_ready), 0);
    chk("led_after_accept", int'(led), exp_led);
    @(posedge sys_clk);
    #1;
    chk("ready_high_again", int'(cfg_ready), 1);
  endtask

  task automatic chk_queues_empty();
    for (int i = 0; i < NCH; i++)
      chk($sformatf("missing_ticks_ch%0d", i), expq[i].size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    sys_rst   = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_mode  = M_OFF;
    cfg_half  = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_led", int'(led), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_ready", int'(cfg_ready), 0);

    // Default BLINK with half 5 on every channel after reset.
    for (int i = 0; i < NCH; i++) begin
      push(i, 5, 1'b1);
      push(i, 10, 1'b0);
    end
    @(negedge sys_clk);
    #2 sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("ready_first_edge", int'(cfg_ready), 1);
    wait_cyc(5);
    chk("blink_rise", int'(led), 7);
    wait_cyc(10);
    chk("blink_fall", int'(led), 0);

    cfg(1, M_OFF, 5, 0);
    cfg(2, M_OFF, 5, 0);
    // Accepted at cycle 15, which is ch0's terminal count.
    cfg(0, M_ON, 5, 1);

    push(1, 20, 1'b0);
    cfg(1, M_ONE, 3, 3);

    for (int c = 20; c <= 25; c++) push(2, c, logic'((c - 19) % 2));
    cfg(2, M_BLINK, 0, 3);
    wait_cyc(25);
    cfg(2, M_OFF, 1, 1);

    cfg(NCH, M_ON, 1, 1);
    chk("out_of_range_no_change", int'(led), 1);

    push(1, 34, 1'b1);
    push(1, 38, 1'b0);
    push(1, 42, 1'b1);
    cfg(1, M_BLINK, 4, 1);
    for (int c = 34; c <= 44; c += 2) push(2, c, logic'(((c - 32) / 2) % 2));
    cfg(2, M_BLINK, 2, 1);
    wait_cyc(43);
    cfg(1, M_OFF, 4, 1);
    cfg(2, M_OFF, 2, 1);
    wait_cyc(50);
    chk("steady_led", int'(led), 1);
    chk_queues_empty();

    // Reset in the middle of a handshake; the pending OFF for ch0 must be dropped.
    cfg_valid = 1'b1;
    cfg_ch    = '0;
    cfg_mode  = M_OFF;
    cfg_half  = CNT_W'(1);
    #2 sys_rst = 1'b1;
    #1;
    chk("midrst_led", int'(led), 0);
    chk("midrst_tick", int'(tick), 0);
    chk("midrst_ready", int'(cfg_ready), 0);
    @(posedge sys_clk);
    #1;
    cfg_valid = 1'b0;
    for (int i = 0; i < NCH; i++) push(i, 5, 1'b1);
    @(negedge sys_clk);
    #2 sys_rst = 1'b0;
    chk("ready_low_before_edge", int'(cfg_ready), 0);
    @(posedge sys_clk);
    #1;
    chk("ready_rise_after_rst", int'(cfg_ready), 1);
    wait_cyc(6);
    chk("blink_restored", int'(led), 7);
    chk_queues_empty();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
